// File: rtl/nco_phase_gen.sv
// Phase accumulator NCO feeding a CORDIC: shadow/active config, coherent sync, wrap pulse.
// Optional phase dither with a 16-bit LFSR is enabled by defining NCO_PHASE_DITHER_EN.
module nco_phase_gen #(
   parameter int PW = 19,
   parameter int AW = 32,
   parameter int IW = 12
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_ce,
   input  logic          i_cfg_wr,
   input  logic [AW-1:0] i_fcw,
   input  logic [PW-1:0] i_poff,
   input  logic [IW-1:0] i_ampl,
   input  logic          i_sync,
   output logic [PW-1:0] o_phase,
   output logic [IW-1:0] o_xval,
   output logic [IW-1:0] o_yval,
   output logic          o_aux,
   output logic          o_wrap
);

   localparam int FW = AW - PW;

   logic [AW-1:0] fcw_s, fcw_a;
   logic [PW-1:0] poff_s, poff_a;
   logic [IW-1:0] ampl_s, ampl_a;
   logic [AW-1:0] acc_r;
   logic          pend_r;
   logic [AW:0]   sum_s;
   logic [PW-1:0] trunc_s;

   assign o_yval = '0;

   // Accumulator add with carry-out kept as the wrap indication
   always_comb begin
      sum_s = {1'b0, acc_r} + {1'b0, fcw_a};
   end

`ifdef NCO_PHASE_DITHER_EN
   logic [15:0] lfsr_r;
   logic [FW:0] dsum_s;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic [15:0] nxt;
      nxt = {1'b0, cur[15:1]};
      if (cur[0]) begin
         nxt = nxt ^ 16'hB400;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

   // Dither only perturbs the truncation; its carry lands in the phase, not in acc
   always_comb begin
      dsum_s  = {1'b0, acc_r[FW-1:0]} + {1'b0, lfsr_r[FW-1:0]};
      trunc_s = acc_r[AW-1:FW] + {{(PW-1){1'b0}}, dsum_s[FW]};
   end

   // LFSR advances once per sample strobe
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         lfsr_r <= 16'hACE1;
      end else if (i_ce) begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end
`else
   // Plain truncation of the accumulator to the output phase width
   always_comb begin
      trunc_s = acc_r[AW-1:FW];
   end
`endif

   // Config shadows, commit on a later strobe, accumulator and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         fcw_s   <= '0;
         poff_s  <= '0;
         ampl_s  <= '0;
         fcw_a   <= '0;
         poff_a  <= '0;
         ampl_a  <= '0;
         acc_r   <= '0;
         pend_r  <= 1'b0;
         o_phase <= '0;
         o_xval  <= '0;
         o_aux   <= 1'b0;
         o_wrap  <= 1'b0;
      end else begin
         if (i_cfg_wr) begin
            fcw_s  <= i_fcw;
            poff_s <= i_poff;
            ampl_s <= i_ampl;
         end
         // A write in a strobe cycle stays pending until the next strobe
         pend_r <= i_cfg_wr | (pend_r & ~i_ce);
         o_aux  <= i_ce;
         if (i_ce) begin
            if (pend_r) begin
               fcw_a  <= fcw_s;
               poff_a <= poff_s;
               ampl_a <= ampl_s;
            end
            o_xval <= ampl_a;
            if (i_sync) begin
               o_phase <= poff_a;
               acc_r   <= fcw_a;
               o_wrap  <= 1'b0;
            end else begin
               o_phase <= trunc_s + poff_a;
               acc_r   <= sum_s[AW-1:0];
               o_wrap  <= sum_s[AW];
            end
         end else begin
            o_wrap <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen: directed vector table, hand sequences,
// and randomized traffic against an arithmetic reference model.
module tb_nco_phase_gen;
   localparam int PW = 19;
   localparam int AW = 32;
   localparam int IW = 12;
   localparam longint unsigned FULL  = 64'h1_0000_0000;
   localparam longint unsigned PFULL = 64'h8_0000;
   localparam longint unsigned IFULL = 64'h1000;

   logic          clk = 1'b0;
   logic          reset, ce, cfg_wr, sync;
   logic [AW-1:0] fcw;
   logic [PW-1:0] poff;
   logic [IW-1:0] ampl;
   logic [PW-1:0] phase;
   logic [IW-1:0] xval, yval;
   logic          aux, wrap;

   always #5 clk = ~clk;

   nco_phase_gen #(.PW(PW), .AW(AW), .IW(IW)) dut (
      .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_cfg_wr(cfg_wr),
      .i_fcw(fcw), .i_poff(poff), .i_ampl(ampl), .i_sync(sync),
      .o_phase(phase), .o_xval(xval), .o_yval(yval), .o_aux(aux), .o_wrap(wrap)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   longint unsigned m_acc, m_fcw_s, m_fcw_a, m_poff_s, m_poff_a, m_ampl_s, m_ampl_a;
   longint unsigned m_lfsr;
   bit              m_pend;
   longint unsigned e_phase, e_xval;
   bit              e_aux, e_wrap;

   typedef struct {
      bit          ce;
      bit          wr;
      logic [31:0] fcw;
      logic [18:0] poff;
      logic [11:0] ampl;
      logic [18:0] ph;
      logic [11:0] xv;
      bit          aux;
      bit          wrap;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      longint unsigned sum, ph;
      if (reset) begin
         m_acc = 0; m_fcw_s = 0; m_fcw_a = 0; m_poff_s = 0; m_poff_a = 0;
         m_ampl_s = 0; m_ampl_a = 0; m_pend = 0; m_lfsr = 64'hACE1;
         e_phase = 0; e_xval = 0; e_aux = 0; e_wrap = 0;
      end else begin
         e_aux = ce;
         if (ce) begin
            e_xval = m_ampl_a;
            if (sync) begin
               e_phase = m_poff_a;
               m_acc   = m_fcw_a;
               e_wrap  = 0;
            end else begin
               ph = m_acc;
`ifdef NCO_PHASE_DITHER_EN
               ph = m_acc + (m_lfsr % (64'd1 << (AW - PW)));
`endif
               e_phase = ((ph >> (AW - PW)) + m_poff_a) % PFULL;
               sum     = m_acc + m_fcw_a;
               e_wrap  = (sum >= FULL);
               m_acc   = sum % FULL;
            end
            if (m_pend) begin
               m_fcw_a = m_fcw_s; m_poff_a = m_poff_s; m_ampl_a = m_ampl_s;
            end
            m_pend = 0;
            if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 64'hB400;
            else                 m_lfsr = m_lfsr / 2;
         end else begin
            e_wrap = 0;
         end
         if (cfg_wr) begin
            m_fcw_s = fcw; m_poff_s = poff; m_ampl_s = ampl; m_pend = 1;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("phase", phase, e_phase);
      chk("xval", xval, e_xval);
      chk("yval", yval, 0);
      chk("aux", aux, e_aux);
      chk("wrap", wrap, e_wrap);
   endtask

   task automatic idle_in();
      reset = 0; ce = 0; cfg_wr = 0; sync = 0;
   endtask

   function automatic vec_t mk(bit c, bit w, logic [31:0] f, logic [18:0] po, logic [11:0] a,
                               logic [18:0] p, logic [11:0] x, bit au, bit wr_o);
      vec_t v;
      v.ce = c; v.wr = w; v.fcw = f; v.poff = po; v.ampl = a;
      v.ph = p; v.xv = x; v.aux = au; v.wrap = wr_o;
      return v;
   endfunction

   initial begin
      // step 2^28 gives 0x8000 per sample at PW=19/AW=32; then 2^30 wraps every 4th
      tbl[0]  = mk(1'b0, 1'b1, 32'h1000_0000, 19'h0, 12'h123, 19'h00000, 12'h000, 1'b0, 1'b0);
      tbl[1]  = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h00000, 12'h000, 1'b1, 1'b0);
      tbl[2]  = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h00000, 12'h123, 1'b1, 1'b0);
      tbl[3]  = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h08000, 12'h123, 1'b1, 1'b0);
      tbl[4]  = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h10000, 12'h123, 1'b1, 1'b0);
      tbl[5]  = mk(1'b0, 1'b0, 32'h0,         19'h0, 12'h123, 19'h10000, 12'h123, 1'b0, 1'b0);
      tbl[6]  = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h18000, 12'h123, 1'b1, 1'b0);
      tbl[7]  = mk(1'b1, 1'b1, 32'h4000_0000, 19'h0, 12'h123, 19'h20000, 12'h123, 1'b1, 1'b0);
      tbl[8]  = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h28000, 12'h123, 1'b1, 1'b0);
      tbl[9]  = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h30000, 12'h123, 1'b1, 1'b0);
      tbl[10] = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h50000, 12'h123, 1'b1, 1'b0);
      tbl[11] = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h70000, 12'h123, 1'b1, 1'b1);
      tbl[12] = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h10000, 12'h123, 1'b1, 1'b0);
      tbl[13] = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h30000, 12'h123, 1'b1, 1'b0);
      tbl[14] = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h50000, 12'h123, 1'b1, 1'b0);
      tbl[15] = mk(1'b1, 1'b0, 32'h0,         19'h0, 12'h123, 19'h70000, 12'h123, 1'b1, 1'b1);

      idle_in();
      fcw = '0; poff = '0; ampl = '0;
      reset = 1;
      cycle();
      cycle();
      chk("rst_phase", phase, 0);
      chk("rst_aux", aux, 0);
      reset = 0;

      for (int i = 0; i < 16; i++) begin
         ce = tbl[i].ce; cfg_wr = tbl[i].wr;
         fcw = tbl[i].fcw; poff = tbl[i].poff; ampl = tbl[i].ampl;
         cycle();
`ifndef NCO_PHASE_DITHER_EN
         chk($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
`endif
         chk($sformatf("tbl%0d_xval", i), xval, tbl[i].xv);
         chk($sformatf("tbl%0d_aux", i), aux, tbl[i].aux);
         chk($sformatf("tbl%0d_wrap", i), wrap, tbl[i].wrap);
      end

      // coherent restart onto the committed offset
      idle_in(); reset = 1; cycle(); reset = 0;
      cfg_wr = 1; fcw = 32'h1000_0000; poff = 19'h40000; ampl = 12'h7FF; cycle();
      cfg_wr = 0; ce = 1; cycle();
      chk("sync_pre", phase, 19'h00000);
      sync = 1; cycle();
      chk("sync_phase", phase, 19'h40000);
      chk("sync_wrap", wrap, 0);
      sync = 0; cycle();
      chk("sync_next", phase, 19'h48000);

      // write coinciding with a strobe: two more old-step samples, then new step
      cfg_wr = 1; fcw = 32'h2000_0000; cycle();
      cfg_wr = 0; cycle(); cycle(); cycle(); cycle();

      // one-in-three strobes: outputs hold between strobes
      for (int i = 0; i < 30; i++) begin
         ce = (i % 3 == 0);
         cycle();
      end

      // randomized traffic with occasional resets, writes and syncs
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(0, 399) == 0);
         ce     = ($urandom_range(0, 3) != 0);
         cfg_wr = ($urandom_range(0, 15) == 0);
         sync   = ($urandom_range(0, 24) == 0);
         fcw    = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 65535);
         poff   = PW'($urandom);
         ampl   = IW'($urandom);
         cycle();
      end

      // reset mid-run clears every output on the next cycle
      idle_in(); ce = 1; cycle();
      reset = 1; ce = 1; cfg_wr = 1; sync = 1; cycle();
      chk("rst_mid_phase", phase, 0);
      chk("rst_mid_xval", xval, 0);
      chk("rst_mid_aux", aux, 0);
      chk("rst_mid_wrap", wrap, 0);
      idle_in(); cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
